// File: rtl/aes_sbox_masked_sched.sv
// Byte-serial scheduler that shares one combinational masked S-box across a whole AES state.
// One fresh PRD word is consumed per byte; results and output masks are collected into data_o/mask_o.
module aes_sbox_masked_sched #(
  parameter int NumBytes = 16,
  parameter int PrdW     = 18
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [1:0]            op_i,
  input  logic [8*NumBytes-1:0] data_i,
  input  logic [8*NumBytes-1:0] mask_i,
  input  logic                  prd_valid_i,
  output logic                  prd_ready_o,
  input  logic [PrdW-1:0]       prd_i,
  output logic [1:0]            sbox_op_o,
  output logic [7:0]            sbox_data_o,
  output logic [7:0]            sbox_mask_o,
  output logic [PrdW-1:0]       sbox_prd_o,
  input  logic [7:0]            sbox_data_i,
  input  logic [7:0]            sbox_mask_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [8*NumBytes-1:0] data_o,
  output logic [8*NumBytes-1:0] mask_o,
  output logic                  busy_o,
  output logic                  op_err_o
);

  localparam int IdxW = (NumBytes > 1) ? $clog2(NumBytes) : 1;
  localparam int StW  = 8 * NumBytes;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [IdxW-1:0]   idx;
  logic [StW-1:0]    job_data, job_mask;
  logic [1:0]        job_op;
  logic              op_err;
  logic              accept, xfer, last, op_legal;

  assign last     = (idx == IdxW'(NumBytes - 1));
  assign op_legal = (op_i == 2'b01) || (op_i == 2'b10);
  assign op_err_o = op_err;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // S-box inputs are forced to zero outside RUN so no stale share lingers on them
  always_comb begin
    state_nxt   = state;
    in_ready_o  = 1'b0;
    prd_ready_o = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = (state != IDLE);
    accept      = 1'b0;
    xfer        = 1'b0;
    sbox_op_o   = 2'b00;
    sbox_data_o = 8'h00;
    sbox_mask_o = 8'h00;
    sbox_prd_o  = '0;
    case (state)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        prd_ready_o = 1'b1;
        sbox_op_o   = job_op;
        sbox_data_o = job_data[idx*8 +: 8];
        sbox_mask_o = job_mask[idx*8 +: 8];
        sbox_prd_o  = prd_i;
        if (prd_valid_i) begin
          xfer = 1'b1;
          if (last) state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Consumed job bytes are wiped so each input share lives only until its S-box pass
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx      <= '0;
      job_data <= '0;
      job_mask <= '0;
      job_op   <= 2'b00;
      op_err   <= 1'b0;
      data_o   <= '0;
      mask_o   <= '0;
    end else begin
      op_err <= 1'b0;
      if (accept) begin
        job_data <= data_i;
        job_mask <= mask_i;
        job_op   <= op_legal ? op_i : 2'b01;
        op_err   <= ~op_legal;
        idx      <= '0;
      end
      if (xfer) begin
        data_o[idx*8 +: 8]   <= sbox_data_i;
        mask_o[idx*8 +: 8]   <= sbox_mask_i;
        job_data[idx*8 +: 8] <= 8'h00;
        job_mask[idx*8 +: 8] <= 8'h00;
        idx                  <= last ? '0 : idx + 1'b1;
      end
      if (state == DONE && out_ready_i) begin
        data_o <= '0;
        mask_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_aes_sbox_masked_sched.sv
// Directed bench for aes_sbox_masked_sched with a behavioural masked S-box whose output
// mask is the low PRD byte, so every result byte reveals which PRD word produced it.
module tb_aes_sbox_masked_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [1:0]   op;
  logic [127:0] data_in, mask_in;
  logic         prd_valid, prd_ready;
  logic [17:0]  prd;
  logic [1:0]   sbox_op;
  logic [7:0]   sbox_data, sbox_mask, sbox_res, sbox_res_mask;
  logic [17:0]  sbox_prd;
  logic         out_valid, out_ready;
  logic [127:0] data_out, mask_out;
  logic         busy, op_err;

  int nvec = 0;
  int nerr = 0;
  int prd_cnt = 0;

  always #5 clk = ~clk;

  aes_sbox_masked_sched #(.NumBytes(16), .PrdW(18)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .op_i(op),
    .data_i(data_in), .mask_i(mask_in),
    .prd_valid_i(prd_valid), .prd_ready_o(prd_ready), .prd_i(prd),
    .sbox_op_o(sbox_op), .sbox_data_o(sbox_data), .sbox_mask_o(sbox_mask),
    .sbox_prd_o(sbox_prd), .sbox_data_i(sbox_res), .sbox_mask_i(sbox_res_mask),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .data_o(data_out), .mask_o(mask_out),
    .busy_o(busy), .op_err_o(op_err)
  );

  function automatic logic [7:0] pm(input int n);
    return 8'(n * 37 + 11);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic       hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] x);
    if (x == 8'h00) return 8'h00;
    for (int i = 1; i < 256; i++)
      if (gmul(8'(i), x) == 8'h01) return 8'(i);
    return 8'h00;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] x, input int n);
    logic [15:0] t = {x, x};
    return t[15-n -: 8];
  endfunction

  function automatic logic [7:0] fwd_sb(input logic [7:0] x);
    logic [7:0] b = ginv(x);
    return b ^ rl(b, 1) ^ rl(b, 2) ^ rl(b, 3) ^ rl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sb(input logic [7:0] x);
    return ginv(rl(x, 1) ^ rl(x, 3) ^ rl(x, 6) ^ 8'h05);
  endfunction

  // byte k takes b where sel[k] is set, a otherwise
  function automatic logic [127:0] build(input logic [7:0] a, input logic [7:0] b,
                                         input logic [15:0] sel);
    logic [127:0] v;
    for (int k = 0; k < 16; k++) v[k*8 +: 8] = sel[k] ? b : a;
    return v;
  endfunction

  assign prd = {prd_cnt[9:0], pm(prd_cnt)};

  logic [7:0] sx, sy;
  always_comb begin
    sx            = sbox_data ^ sbox_mask;
    sy            = (sbox_op == 2'b10) ? inv_sb(sx) : fwd_sb(sx);
    sbox_res      = sy ^ sbox_prd[7:0];
    sbox_res_mask = sbox_prd[7:0];
  end

  always @(posedge clk)
    if (!rst && prd_valid && prd_ready) prd_cnt <= prd_cnt + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"}, 128'(in_ready), 128'd1);
    chk({tag, "_out_valid"}, 128'(out_valid), 128'd0);
    chk({tag, "_prd_ready"}, 128'(prd_ready), 128'd0);
    chk({tag, "_busy"}, 128'(busy), 128'd0);
    chk({tag, "_op_err"}, 128'(op_err), 128'd0);
    chk({tag, "_data_o"}, data_out, 128'd0);
    chk({tag, "_mask_o"}, mask_out, 128'd0);
    chk({tag, "_sbox_in"}, {sbox_op, sbox_data, sbox_mask, sbox_prd}, 128'd0);
  endtask

  task automatic run_job(input logic [127:0] d, input logic [127:0] m, input logic [1:0] o,
                         input bit stall, output int base, output int lat);
    int  n;
    bit  legal;
    legal = (o == 2'b01) || (o == 2'b10);
    chk("accept_ready", 128'(in_ready), 128'd1);
    in_valid = 1'b1;
    data_in  = d;
    mask_in  = m;
    op       = o;
    @(posedge clk); #1;
    in_valid = 1'b0;
    base = prd_cnt;
    n = 1;
    chk("op_err", 128'(op_err), 128'(!legal));
    chk("sbox_op", 128'(sbox_op), legal ? 128'(o) : 128'd1);
    chk("busy_run", 128'(busy), 128'd1);
    chk("in_ready_run", 128'(in_ready), 128'd0);
    while (!out_valid && n < 100) begin
      prd_valid = !(stall && n >= 6 && n < 9);
      @(posedge clk); #1;
      n++;
      if (n == 2) chk("op_err_pulse", 128'(op_err), 128'd0);
    end
    prd_valid = 1'b1;
    if (n >= 100) chk("timeout", 128'(out_valid), 128'd1);
    lat = n;
    chk("xfers", 128'(prd_cnt - base), 128'd16);
  endtask

  task automatic chk_res(input string tag, input int base, input logic [127:0] exp);
    logic [127:0] em;
    for (int k = 0; k < 16; k++) em[k*8 +: 8] = pm(base + k);
    chk({tag, "_unmasked"}, data_out ^ mask_out, exp);
    chk({tag, "_mask"}, mask_out, em);
  endtask

  task automatic release_job(input int hold);
    logic [127:0] sd, sm;
    sd = data_out;
    sm = mask_out;
    out_ready = 1'b0;
    in_valid  = (hold > 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
    end
    if (hold > 0) begin
      chk("bp_data_stable", data_out, sd);
      chk("bp_mask_stable", mask_out, sm);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
      chk("bp_out_valid", 128'(out_valid), 128'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk_idle("release");
  endtask

  int base, lat;
  logic [127:0] plain, mk;

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = 2'b00; data_in = '0; mask_in = '0;
    prd_valid = 1'b1; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_idle("reset");

    // T1: reset in the middle of a job
    in_valid = 1'b1; op = 2'b01; data_in = build(8'h12, 8'h34, 16'h5555); mask_in = '0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_idle("midrun_reset");

    // T2: forward, unmasked
    run_job(build(8'h00, 8'h53, 16'hAAAA), '0, 2'b01, 1'b0, base, lat);
    chk("t2_lat", 128'(lat), 128'd17);
    chk_res("t2", base, build(8'h63, 8'hED, 16'hAAAA));
    release_job(0);

    // T3: inverse, masked
    run_job(build(8'h63 ^ 8'hA5, 8'hED ^ 8'h3C, 16'hFF00), build(8'hA5, 8'h3C, 16'hFF00),
            2'b10, 1'b0, base, lat);
    chk("t3_lat", 128'(lat), 128'd17);
    chk_res("t3", base, build(8'h00, 8'h53, 16'hFF00));
    release_job(0);

    // T5 + T6: illegal op behaves as encrypt, then held in DONE under backpressure
    run_job(build(8'h00, 8'h53, 16'h0F0F), '0, 2'b11, 1'b0, base, lat);
    chk("t5_lat", 128'(lat), 128'd17);
    chk_res("t5", base, build(8'h63, 8'hED, 16'h0F0F));
    release_job(10);

    // T4: back-to-back job with per-byte masks and a 3-cycle PRD stall at idx 5
    plain = build(8'h00, 8'h53, 16'h1008);
    for (int k = 0; k < 16; k++) mk[k*8 +: 8] = 8'(k * 29 + 1);
    run_job(plain ^ mk, mk, 2'b01, 1'b1, base, lat);
    chk("t4_lat", 128'(lat), 128'd20);
    chk_res("t4", base, build(8'h63, 8'hED, 16'h1008));
    release_job(0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
